// File: rtl/mc_alu_ctrl.sv
// Multicycle-CPU main controller: steps each instruction and drives the ALU op and the operand muxes.
// Define MC_ALU_CTRL_OVF_TRAP_EN to trap on signed add/sub/addi overflow instead of writing back.
module mc_alu_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic [2:0] ALU_operation,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ovf_trap,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EX     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EX     = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd12;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [3:0] next_state;
    logic [2:0] r_op;
    logic       r_known;
    logic [2:0] i_op;

`ifdef MC_ALU_CTRL_OVF_TRAP_EN
    logic r_trap;
    logic i_trap;
    assign r_trap = overflow && (fn_q == FN_ADD || fn_q == FN_SUB);
    assign i_trap = overflow && (op_q == OP_ADDI);
`else
    logic ovf_unused;
    assign ovf_unused = overflow;
`endif

    // R-type ALU function from the funct field captured in DECODE.
    always_comb begin
        r_op    = ALU_ADD;
        r_known = 1'b1;
        case (fn_q)
            6'b100000, 6'b100001: r_op = ALU_ADD;
            6'b100010, 6'b100011: r_op = ALU_SUB;
            6'b100100:            r_op = ALU_AND;
            6'b100101:            r_op = ALU_OR;
            6'b100110:            r_op = ALU_XOR;
            6'b100111:            r_op = ALU_NOR;
            6'b101010:            r_op = ALU_SLT;
            6'b000010:            r_op = ALU_SRL;
            default:              r_known = 1'b0;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            default: i_op = ALU_ADD;
        endcase
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                next_state = S_R_EX;
                    OP_LW, OP_SW:            next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          next_state = S_BRANCH;
                    OP_J:                    next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: next_state = S_I_EX;
                    default:                 next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX: begin
                if (!r_known)
                    next_state = S_FETCH;
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
                else if (r_trap)
                    next_state = S_TRAP;
`endif
                else
                    next_state = S_R_WB;
            end
            S_R_WB:     next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
            S_I_EX:     next_state = i_trap ? S_TRAP : S_I_WB;
            S_TRAP:     next_state = S_FETCH;
`else
            S_I_EX:     next_state = S_I_WB;
`endif
            S_I_WB:     next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
            op_q  <= 6'd0;
            fn_q  <= 6'd0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    // Reset masks every strobe combinationally so nothing leaks out while rst is high.
    always_comb begin
        ALU_operation = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        ovf_trap      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a     = 1'b1;
                    ALU_operation = r_op;
                end
                S_R_WB: begin
                    reg_write     = 1'b1;
                    reg_dst       = 1'b1;
                    ALU_operation = r_op;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    ALU_operation = ALU_SUB;
                    pc_source     = 2'b01;
                    pc_write      = (op_q == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_EX: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = 2'b10;
                    ALU_operation = i_op;
                end
                S_I_WB:     reg_write = 1'b1;
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
                S_TRAP:     ovf_trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu_ctrl.sv
// Directed per-cycle vector bench for mc_alu_ctrl; expectations are hand-computed constants.
module tb_mc_alu_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       pw;
        logic [1:0] ps;
        logic [7:0] stb;   // ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, ovf_trap
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        logic       overflow;
        logic       mem_ready;
        outs_t      exp;
    } vec_t;

    logic       clk, rst, zero, overflow, mem_ready;
    logic [5:0] opcode, funct;
    logic [2:0] ALU_operation;
    logic       alu_src_a, pc_write, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, ovf_trap;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] state;
    outs_t      act;
    int         checks = 0;
    int         errors = 0;

    mc_alu_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready), .ALU_operation(ALU_operation),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
        .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ovf_trap(ovf_trap), .state(state)
    );

    assign act = {state, ALU_operation, alu_src_a, alu_src_b, pc_write, pc_source,
                  ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, ovf_trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] F0   = 8'b0100_0000;
    localparam logic [7:0] F1   = 8'b1100_0000;
    localparam logic [7:0] MRD  = 8'b0101_0000;
    localparam logic [7:0] MWB  = 8'b0000_1010;
    localparam logic [7:0] MWR  = 8'b0011_0000;
    localparam logic [7:0] RWB  = 8'b0000_1100;
    localparam logic [7:0] IWB  = 8'b0000_1000;
    localparam logic [7:0] TRP  = 8'b0000_0001;
    localparam logic [5:0] XX   = 6'h3f;   // garbage on IR fields outside DECODE

    function automatic outs_t e(input logic [3:0] st, input logic [2:0] alu, input logic sa,
                                input logic [1:0] sb, input logic pw, input logic [1:0] ps,
                                input logic [7:0] stb);
        return {st, alu, sa, sb, pw, ps, stb};
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic ov, input logic mr, input outs_t ex);
        vec_t v;
        v.rst = r; v.opcode = op; v.funct = fn; v.zero = z;
        v.overflow = ov; v.mem_ready = mr; v.exp = ex;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, check mid-cycle, advance one clock.
    task automatic step(input vec_t v, input string tag);
        rst = v.rst; opcode = v.opcode; funct = v.funct;
        zero = v.zero; overflow = v.overflow; mem_ready = v.mem_ready;
        @(negedge clk);
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s: got st=%0d alu=%b sa=%b sb=%b pw=%b ps=%b stb=%b, want st=%0d alu=%b sa=%b sb=%b pw=%b ps=%b stb=%b",
                     tag, act.st, act.alu, act.sa, act.sb, act.pw, act.ps, act.stb,
                     v.exp.st, v.exp.alu, v.exp.sa, v.exp.sb, v.exp.pw, v.exp.ps, v.exp.stb);
        end
        if (reg_write && pc_write) begin
            errors++;
            $display("FAIL %s: reg_write and pc_write both high", tag);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk(1, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b00, 0, 2'b00, NONE)));  // in reset
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000000, 6'b100010, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(6, 3'b110, 1, 2'b00, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(7, 3'b110, 0, 2'b00, 0, 2'b00, RWB)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        // beq taken / not taken, bne taken / not taken
        tbl.push_back(mk(0, 6'b000100, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 1, 0, 1, e(8, 3'b110, 1, 2'b00, 1, 2'b01, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000100, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(8, 3'b110, 1, 2'b00, 0, 2'b01, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000101, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(8, 3'b110, 1, 2'b00, 1, 2'b01, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000101, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 1, 0, 1, e(8, 3'b110, 1, 2'b00, 0, 2'b01, NONE)));
        // lw with two wait cycles in MEM_RD
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b100011, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(2, 3'b010, 1, 2'b10, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(3, 3'b010, 0, 2'b00, 0, 2'b00, MRD)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(3, 3'b010, 0, 2'b00, 0, 2'b00, MRD)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(3, 3'b010, 0, 2'b00, 0, 2'b00, MRD)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(4, 3'b010, 0, 2'b00, 0, 2'b00, MWB)));
        // sw with one wait cycle
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b101011, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(2, 3'b010, 1, 2'b10, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(5, 3'b010, 0, 2'b00, 0, 2'b00, MWR)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(5, 3'b010, 0, 2'b00, 0, 2'b00, MWR)));
        // j
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000010, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(9, 3'b010, 0, 2'b00, 1, 2'b10, NONE)));
        // ori, andi
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b001101, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(10, 3'b001, 1, 2'b10, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(11, 3'b010, 0, 2'b00, 0, 2'b00, IWB)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b001100, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(10, 3'b000, 1, 2'b10, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(11, 3'b010, 0, 2'b00, 0, 2'b00, IWB)));
        // unknown opcode is a nop, unknown funct aborts without writeback
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b111111, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000000, 6'b111111, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(6, 3'b010, 1, 2'b00, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)));
        // slt
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)));
        tbl.push_back(mk(0, 6'b000000, 6'b101010, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(6, 3'b111, 1, 2'b00, 0, 2'b00, NONE)));
        tbl.push_back(mk(0, XX, XX, 0, 0, 1, e(7, 3'b111, 0, 2'b00, 0, 2'b00, RWB)));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // add overflowing in R_EX
        step(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)), "add_fetch");
        step(mk(0, 6'b000000, 6'b100000, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)), "add_decode");
        step(mk(0, XX, XX, 0, 1, 1, e(6, 3'b010, 1, 2'b00, 0, 2'b00, NONE)), "add_ex_ovf");
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
        step(mk(0, XX, XX, 0, 1, 1, e(12, 3'b010, 0, 2'b00, 0, 2'b00, TRP)), "add_trap");
`else
        step(mk(0, XX, XX, 0, 1, 1, e(7, 3'b010, 0, 2'b00, 0, 2'b00, RWB)), "add_wb");
`endif
        step(mk(0, XX, XX, 0, 1, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)), "add_after");

        // addu never traps
        step(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)), "addu_fetch");
        step(mk(0, 6'b000000, 6'b100001, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)), "addu_decode");
        step(mk(0, XX, XX, 0, 1, 1, e(6, 3'b010, 1, 2'b00, 0, 2'b00, NONE)), "addu_ex_ovf");
        step(mk(0, XX, XX, 0, 1, 1, e(7, 3'b010, 0, 2'b00, 0, 2'b00, RWB)), "addu_wb");

        // addi overflowing in I_EX
        step(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)), "addi_fetch");
        step(mk(0, 6'b001000, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)), "addi_decode");
        step(mk(0, XX, XX, 0, 1, 1, e(10, 3'b010, 1, 2'b10, 0, 2'b00, NONE)), "addi_ex_ovf");
`ifdef MC_ALU_CTRL_OVF_TRAP_EN
        step(mk(0, XX, XX, 0, 0, 1, e(12, 3'b010, 0, 2'b00, 0, 2'b00, TRP)), "addi_trap");
`else
        step(mk(0, XX, XX, 0, 0, 1, e(11, 3'b010, 0, 2'b00, 0, 2'b00, IWB)), "addi_wb");
`endif
        step(mk(0, XX, XX, 0, 0, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)), "addi_after");

        // reset asserted during a MEM_RD wait
        step(mk(0, XX, XX, 0, 0, 1, e(0, 3'b010, 0, 2'b01, 1, 2'b00, F1)), "rstw_fetch");
        step(mk(0, 6'b100011, XX, 0, 0, 1, e(1, 3'b010, 0, 2'b11, 0, 2'b00, NONE)), "rstw_decode");
        step(mk(0, XX, XX, 0, 0, 0, e(2, 3'b010, 1, 2'b10, 0, 2'b00, NONE)), "rstw_addr");
        step(mk(0, XX, XX, 0, 0, 0, e(3, 3'b010, 0, 2'b00, 0, 2'b00, MRD)), "rstw_wait");
        step(mk(1, XX, XX, 0, 0, 0, e(3, 3'b010, 0, 2'b00, 0, 2'b00, NONE)), "rstw_rst");
        step(mk(0, XX, XX, 0, 0, 0, e(0, 3'b010, 0, 2'b01, 0, 2'b00, F0)), "rstw_fetch_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
